// File: rtl/sddt_cmd_streamer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sddt_cmd_streamer                                                     |
// | Replays preloaded command / write-data beats and collects read beats. |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module sddt_cmd_streamer #(
    parameter int CMD_DEPTH   = 64,
    parameter int WDATA_DEPTH = 16,
    parameter int RD_DEPTH    = 16,
    parameter int TIMEOUT     = 4096
) (
    input  logic                           axi_aclk,
    input  logic                           axi_aresetn,
    input  logic                           prog_we,
    input  logic [$clog2(CMD_DEPTH)-1:0]   prog_addr,
    input  logic [127:0]                   prog_data,
    input  logic                           wmem_we,
    input  logic [$clog2(WDATA_DEPTH)-1:0] wmem_addr,
    input  logic [511:0]                   wmem_data,
    input  logic                           start,
    input  logic [$clog2(CMD_DEPTH):0]     cmd_count,
    input  logic [$clog2(WDATA_DEPTH):0]   wdata_count,
    input  logic [15:0]                    rd_expect,
    output logic [127:0]                   M_AXIS_CMD_tdata,
    output logic                           M_AXIS_CMD_tvalid,
    input  logic                           M_AXIS_CMD_tready,
    output logic [511:0]                   M_AXIS_WDATA_tdata,
    output logic                           M_AXIS_WDATA_tvalid,
    input  logic                           M_AXIS_WDATA_tready,
    input  logic [511:0]                   S_AXIS_RDATA_tdata,
    input  logic                           S_AXIS_RDATA_tvalid,
    output logic                           S_AXIS_RDATA_tready,
    input  logic [$clog2(RD_DEPTH)-1:0]    rb_addr,
    output logic [511:0]                   rb_data,
    output logic                           busy,
    output logic                           done,
    output logic                           timeout,
    output logic                           overflow,
    output logic                           stray,
    output logic [15:0]                    rd_count
);
    localparam int c_caw = $clog2(CMD_DEPTH);
    localparam int c_waw = $clog2(WDATA_DEPTH);
    localparam int c_raw = $clog2(RD_DEPTH);
    localparam int c_iw  = $clog2(TIMEOUT + 1);
    localparam logic [c_iw-1:0] c_timeout = c_iw'(TIMEOUT);
    localparam logic [c_caw:0]  c_cmd_one = (c_caw + 1)'(1);
    localparam logic [c_waw:0]  c_wd_one  = (c_waw + 1)'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t r_state, w_next;

    logic [127:0] r_cmd_mem [CMD_DEPTH];
    logic [511:0] r_wd_mem  [WDATA_DEPTH];
    logic [511:0] r_rb_mem  [RD_DEPTH];

    logic [c_caw:0]  r_cmd_cnt, r_cmd_idx;
    logic [c_waw:0]  r_wd_cnt, r_wd_idx;
    logic [15:0]     r_rd_expect;
    logic [c_raw:0]  r_rb_ptr;
    logic [c_iw-1:0] r_idle;

    logic w_start_ok, w_all_zero, w_capture, w_stray_beat;
    logic w_cmd_hs, w_cmd_step, w_cmd_ld_more, w_cmd_ld_last, w_cmd_fin;
    logic w_wd_hs, w_wd_step, w_wd_ld_more, w_wd_fin;
    logic w_count_hit, w_idle_exp, w_enter_drain;
    logic [c_caw:0] w_cmd_cnt_eff, w_cmd_ld_idx;
    logic [c_waw:0] w_wd_cnt_eff, w_wd_ld_idx;
    logic [127:0]   w_cmd_ld_word;

    assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_all_zero = (cmd_count == '0) && (wdata_count == '0) && (rd_expect == '0);
    assign w_capture  = S_AXIS_RDATA_tvalid && ((r_state == STREAM) || (r_state == DRAIN));
    assign w_stray_beat = S_AXIS_RDATA_tvalid && (!w_capture || (rd_count >= r_rd_expect));

    // The next word to present: word 0 on start, otherwise the successor of the one just taken.
    assign w_cmd_hs      = M_AXIS_CMD_tvalid && M_AXIS_CMD_tready;
    assign w_cmd_step    = w_start_ok || w_cmd_hs;
    assign w_cmd_cnt_eff = w_start_ok ? cmd_count : r_cmd_cnt;
    assign w_cmd_ld_idx  = w_start_ok ? '0 : (r_cmd_idx + c_cmd_one);
    assign w_cmd_ld_more = w_cmd_ld_idx < w_cmd_cnt_eff;
    assign w_cmd_ld_last = w_cmd_ld_idx == (w_cmd_cnt_eff - c_cmd_one);
    assign w_cmd_ld_word = r_cmd_mem[w_cmd_ld_idx[c_caw-1:0]];
    assign w_cmd_fin     = !M_AXIS_CMD_tvalid || (w_cmd_hs && !w_cmd_ld_more);

    assign w_wd_hs      = M_AXIS_WDATA_tvalid && M_AXIS_WDATA_tready;
    assign w_wd_step    = w_start_ok || w_wd_hs;
    assign w_wd_cnt_eff = w_start_ok ? wdata_count : r_wd_cnt;
    assign w_wd_ld_idx  = w_start_ok ? '0 : (r_wd_idx + c_wd_one);
    assign w_wd_ld_more = w_wd_ld_idx < w_wd_cnt_eff;
    assign w_wd_fin     = !M_AXIS_WDATA_tvalid || (w_wd_hs && !w_wd_ld_more);

    assign w_count_hit   = rd_count == r_rd_expect;
    assign w_idle_exp    = r_idle == c_timeout;
    assign w_enter_drain = (r_state == STREAM) && (w_next == DRAIN);

    assign busy                = (r_state == STREAM) || (r_state == DRAIN);
    assign done                = r_state == DONE;
    assign S_AXIS_RDATA_tready = 1'b1;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) r_state <= IDLE;
        else              r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: if (start) w_next = w_all_zero ? DONE : STREAM;
            STREAM:     if (w_cmd_fin && w_wd_fin) w_next = DRAIN;
            DRAIN:      if (w_count_hit || w_idle_exp) w_next = DONE;
            default:    w_next = IDLE;
        endcase
    end

    // Memories carry no reset so their contents survive a mid-run abort.
    always_ff @(posedge axi_aclk) begin
        if (prog_we) r_cmd_mem[prog_addr] <= prog_data;
        if (wmem_we) r_wd_mem[wmem_addr] <= wmem_data;
        if (w_capture && !r_rb_ptr[c_raw]) r_rb_mem[r_rb_ptr[c_raw-1:0]] <= S_AXIS_RDATA_tdata;
        rb_data <= r_rb_mem[rb_addr];
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            M_AXIS_CMD_tdata    <= '0;
            M_AXIS_CMD_tvalid   <= 1'b0;
            M_AXIS_WDATA_tdata  <= '0;
            M_AXIS_WDATA_tvalid <= 1'b0;
            r_cmd_cnt   <= '0;
            r_cmd_idx   <= '0;
            r_wd_cnt    <= '0;
            r_wd_idx    <= '0;
            r_rd_expect <= '0;
            r_rb_ptr    <= '0;
            r_idle      <= '0;
            rd_count    <= '0;
            timeout     <= 1'b0;
            overflow    <= 1'b0;
            stray       <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_cmd_cnt   <= cmd_count;
                r_wd_cnt    <= wdata_count;
                r_rd_expect <= rd_expect;
            end

            if (w_cmd_step) begin
                M_AXIS_CMD_tvalid <= w_cmd_ld_more;
                if (w_cmd_ld_more) begin
                    r_cmd_idx        <= w_cmd_ld_idx;
                    M_AXIS_CMD_tdata <= {w_cmd_ld_word[127] & ~w_cmd_ld_last, w_cmd_ld_word[126:0]};
                end
            end

            if (w_wd_step) begin
                M_AXIS_WDATA_tvalid <= w_wd_ld_more;
                if (w_wd_ld_more) begin
                    r_wd_idx           <= w_wd_ld_idx;
                    M_AXIS_WDATA_tdata <= r_wd_mem[w_wd_ld_idx[c_waw-1:0]];
                end
            end

            if (w_start_ok) begin
                r_rb_ptr <= '0;
                rd_count <= '0;
                overflow <= 1'b0;
            end else if (w_capture) begin
                if (!r_rb_ptr[c_raw]) r_rb_ptr <= r_rb_ptr + (c_raw + 1)'(1);
                else                  overflow <= 1'b1;
                if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
            end

            if (w_start_ok)        stray <= 1'b0;
            else if (w_stray_beat) stray <= 1'b1;

            if (w_start_ok || w_enter_drain || w_capture) r_idle <= '0;
            else if ((r_state == DRAIN) && !w_idle_exp)   r_idle <= r_idle + c_iw'(1);

            if (w_start_ok) timeout <= 1'b0;
            else if ((r_state == DRAIN) && w_idle_exp && !w_count_hit) timeout <= 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_sddt_cmd_streamer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_sddt_cmd_streamer                                                  |
// | Scoreboard and vector-table bench for the command/data streamer.      |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_sddt_cmd_streamer;
    localparam int c_timeout = 16;

    logic         axi_aclk = 1'b0;
    logic         axi_aresetn = 1'b0;
    logic         prog_we = 1'b0;
    logic [5:0]   prog_addr = '0;
    logic [127:0] prog_data = '0;
    logic         wmem_we = 1'b0;
    logic [3:0]   wmem_addr = '0;
    logic [511:0] wmem_data = '0;
    logic         start = 1'b0;
    logic [6:0]   cmd_count = '0;
    logic [4:0]   wdata_count = '0;
    logic [15:0]  rd_expect = '0;
    logic [127:0] cmd_tdata;
    logic         cmd_tvalid;
    logic         cmd_tready = 1'b0;
    logic [511:0] wd_tdata;
    logic         wd_tvalid;
    logic         wd_tready = 1'b0;
    logic [511:0] rd_tdata = '0;
    logic         rd_tvalid = 1'b0;
    logic         rd_tready;
    logic [3:0]   rb_addr = '0;
    logic [511:0] rb_data;
    logic         busy, done, timeout, overflow, stray;
    logic [15:0]  rd_count;

    sddt_cmd_streamer #(
        .CMD_DEPTH(64), .WDATA_DEPTH(16), .RD_DEPTH(16), .TIMEOUT(c_timeout)
    ) dut (
        .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .wmem_we(wmem_we), .wmem_addr(wmem_addr), .wmem_data(wmem_data),
        .start(start), .cmd_count(cmd_count), .wdata_count(wdata_count), .rd_expect(rd_expect),
        .M_AXIS_CMD_tdata(cmd_tdata), .M_AXIS_CMD_tvalid(cmd_tvalid), .M_AXIS_CMD_tready(cmd_tready),
        .M_AXIS_WDATA_tdata(wd_tdata), .M_AXIS_WDATA_tvalid(wd_tvalid), .M_AXIS_WDATA_tready(wd_tready),
        .S_AXIS_RDATA_tdata(rd_tdata), .S_AXIS_RDATA_tvalid(rd_tvalid), .S_AXIS_RDATA_tready(rd_tready),
        .rb_addr(rb_addr), .rb_data(rb_data),
        .busy(busy), .done(done), .timeout(timeout), .overflow(overflow), .stray(stray),
        .rd_count(rd_count)
    );

    always #5 axi_aclk = ~axi_aclk;

    typedef struct {
        int cmd_n;
        int wd_n;
        int rd_exp;
        int beats;
        int ready_mode;
        bit exp_timeout;
        bit exp_overflow;
        int exp_rd_count;
    } vec_t;

    int checks = 0;
    int failures = 0;
    int ready_mode = 1;   // 0: hold low, 1: hold high, 2: random
    logic [127:0] exp_prog [64];
    logic [511:0] exp_wmem [16];
    logic [511:0] exp_rb [16];
    logic [127:0] cmd_q [$];
    logic [511:0] wd_q [$];
    vec_t vecs [5];

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [511:0] beat_val(input int run, input int i);
        logic [31:0] t;
        t = 32'hA5A5_0000 ^ 32'(run * 1000 + i);
        return {16{t}};
    endfunction

    // Back-pressure driver for both outgoing streams.
    initial begin
        forever begin
            @(posedge axi_aclk);
            #1;
            cmd_tready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
            wd_tready  = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
        end
    end

    // Output monitor: stability while stalled, and in-order scoreboard compare on each transfer.
    initial begin
        logic         cmd_pend, wd_pend;
        logic [127:0] cmd_held;
        logic [511:0] wd_held;
        cmd_pend = 1'b0;
        wd_pend  = 1'b0;
        forever begin
            @(negedge axi_aclk);
            if (!axi_aresetn) begin
                cmd_pend = 1'b0;
                wd_pend  = 1'b0;
            end else begin
                if (cmd_pend) begin
                    chk("cmd_hold_valid", 512'(cmd_tvalid), 512'(1));
                    chk("cmd_hold_data", 512'(cmd_tdata), 512'(cmd_held));
                end
                if (wd_pend) begin
                    chk("wd_hold_valid", 512'(wd_tvalid), 512'(1));
                    chk("wd_hold_data", wd_tdata, wd_held);
                end
                if (cmd_tvalid && cmd_tready) begin
                    if (cmd_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL cmd_extra actual=%0h required=none", cmd_tdata);
                    end else chk("cmd_word", 512'(cmd_tdata), 512'(cmd_q.pop_front()));
                end
                if (wd_tvalid && wd_tready) begin
                    if (wd_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL wd_extra actual=%0h required=none", wd_tdata);
                    end else chk("wd_word", wd_tdata, wd_q.pop_front());
                end
                cmd_pend = cmd_tvalid && !cmd_tready;
                cmd_held = cmd_tdata;
                wd_pend  = wd_tvalid && !wd_tready;
                wd_held  = wd_tdata;
            end
        end
    end

    task automatic push_expected(input int cn, input int wn);
        logic [127:0] w;
        for (int i = 0; i < cn; i++) begin
            w = exp_prog[i];
            if (i == cn - 1) w[127] = 1'b0;
            cmd_q.push_back(w);
        end
        for (int i = 0; i < wn; i++) wd_q.push_back(exp_wmem[i]);
    endtask

    task automatic pulse_start(input int cn, input int wn, input int re);
        @(posedge axi_aclk); #1;
        start = 1'b1;
        cmd_count = 7'(cn);
        wdata_count = 5'(wn);
        rd_expect = 16'(re);
        @(posedge axi_aclk); #1;
        start = 1'b0;
    endtask

    task automatic send_beats(input int run, input int n);
        for (int i = 0; i < n; i++) begin
            rd_tvalid = 1'b1;
            rd_tdata  = beat_val(run, i);
            if (i < 16) exp_rb[i] = beat_val(run, i);
            @(posedge axi_aclk); #1;
        end
        rd_tvalid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 4000; i++) begin
            @(negedge axi_aclk);
            if (done) break;
        end
        chk("done_reached", 512'(done), 512'(1));
    endtask

    task automatic run_vec(input vec_t v, input int run);
        ready_mode = v.ready_mode;
        push_expected(v.cmd_n, v.wd_n);
        pulse_start(v.cmd_n, v.wd_n, v.rd_exp);
        send_beats(run, v.beats);
        wait_done();
        repeat (2) @(negedge axi_aclk);
        chk("busy_after", 512'(busy), 512'(0));
        chk("rd_count", 512'(rd_count), 512'(v.exp_rd_count));
        chk("timeout", 512'(timeout), 512'(v.exp_timeout));
        chk("overflow", 512'(overflow), 512'(v.exp_overflow));
        chk("stray", 512'(stray), 512'(0));
        chk("cmd_q_drained", 512'(cmd_q.size()), 512'(0));
        chk("wd_q_drained", 512'(wd_q.size()), 512'(0));
        for (int i = 0; i < v.beats && i < 16; i++) begin
            @(posedge axi_aclk); #1;
            rb_addr = 4'(i);
            @(posedge axi_aclk); #1;
            chk("rb_entry", rb_data, exp_rb[i]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_watchdog actual=timeout required=finish");
        $fatal(1, "bench watchdog");
    end

    initial begin
        int first_j;
        vecs[0] = '{3, 2, 2, 2, 1, 1'b0, 1'b0, 2};
        vecs[1] = '{64, 16, 0, 0, 2, 1'b0, 1'b0, 0};
        vecs[2] = '{2, 1, 20, 20, 2, 1'b0, 1'b1, 20};
        vecs[3] = '{0, 0, 0, 0, 2, 1'b0, 1'b0, 0};
        vecs[4] = '{6, 5, 4, 4, 2, 1'b0, 1'b0, 4};

        repeat (3) @(posedge axi_aclk);
        @(negedge axi_aclk);
        axi_aresetn = 1'b1;
        @(negedge axi_aclk);
        chk("rst_cmd_tvalid", 512'(cmd_tvalid), 512'(0));
        chk("rst_wd_tvalid", 512'(wd_tvalid), 512'(0));
        chk("rst_cmd_tdata", 512'(cmd_tdata), 512'(0));
        chk("rst_wd_tdata", wd_tdata, 512'(0));
        chk("rst_status", 512'({busy, done, timeout, overflow, stray}), 512'(0));
        chk("rst_rd_count", 512'(rd_count), 512'(0));
        chk("rd_tready", 512'(rd_tready), 512'(1));

        for (int i = 0; i < 64; i++) begin
            exp_prog[i] = {$urandom, $urandom, $urandom, $urandom};
            if (i < 3) exp_prog[i][127] = 1'b1;
            @(posedge axi_aclk); #1;
            prog_we = 1'b1; prog_addr = 6'(i); prog_data = exp_prog[i];
        end
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 16; k++) exp_wmem[i][k*32 +: 32] = $urandom;
            @(posedge axi_aclk); #1;
            prog_we = 1'b0;
            wmem_we = 1'b1; wmem_addr = 4'(i); wmem_data = exp_wmem[i];
        end
        @(posedge axi_aclk); #1;
        wmem_we = 1'b0;

        for (int v = 0; v < 5; v++) run_vec(vecs[v], v);

        // Watchdog: one beat of three, then silence; done must follow DRAIN entry by TIMEOUT+1 cycles.
        ready_mode = 1;
        repeat (3) @(posedge axi_aclk);
        push_expected(4, 0);
        pulse_start(4, 0, 3);
        send_beats(10, 1);
        for (int i = 0; i < 50; i++) begin
            @(negedge axi_aclk);
            if (!cmd_tvalid) break;
        end
        first_j = -1;
        for (int j = 0; j < 60; j++) begin
            if (done) begin first_j = j; break; end
            @(negedge axi_aclk);
        end
        chk("timeout_latency", 512'(first_j), 512'(c_timeout + 1));
        chk("timeout_flag", 512'(timeout), 512'(1));
        chk("timeout_rd_count", 512'(rd_count), 512'(1));

        // A second start while busy must not alter the run in progress.
        ready_mode = 0;
        repeat (2) @(posedge axi_aclk);
        push_expected(8, 4);
        pulse_start(8, 4, 0);
        @(negedge axi_aclk);
        chk("start_clears_timeout", 512'(timeout), 512'(0));
        pulse_start(2, 1, 5);
        @(negedge axi_aclk);
        chk("busy_streaming", 512'(busy), 512'(1));
        ready_mode = 1;
        wait_done();
        repeat (c_timeout + 4) @(negedge axi_aclk);
        chk("ignored_start_q", 512'(cmd_q.size() + wd_q.size()), 512'(0));
        chk("ignored_start_timeout", 512'(timeout), 512'(0));
        chk("ignored_start_rd_count", 512'(rd_count), 512'(0));

        // Asynchronous reset in the middle of a stalled stream.
        ready_mode = 0;
        repeat (2) @(posedge axi_aclk);
        push_expected(10, 4);
        pulse_start(10, 4, 0);
        repeat (3) @(posedge axi_aclk);
        @(negedge axi_aclk);
        chk("pre_reset_tvalid", 512'(cmd_tvalid), 512'(1));
        axi_aresetn = 1'b0;
        #1;
        chk("reset_cmd_tvalid", 512'(cmd_tvalid), 512'(0));
        chk("reset_wd_tvalid", 512'(wd_tvalid), 512'(0));
        chk("reset_busy", 512'(busy), 512'(0));
        cmd_q.delete();
        wd_q.delete();
        @(negedge axi_aclk);
        axi_aresetn = 1'b1;

        // A beat arriving in IDLE is discarded and flagged.
        @(posedge axi_aclk); #1;
        rd_tvalid = 1'b1; rd_tdata = beat_val(99, 0);
        @(posedge axi_aclk); #1;
        rd_tvalid = 1'b0;
        @(negedge axi_aclk);
        chk("idle_stray", 512'(stray), 512'(1));
        chk("idle_rd_count", 512'(rd_count), 512'(0));

        run_vec('{5, 3, 2, 2, 2, 1'b0, 1'b0, 2}, 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
